// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler: fixed-latency FSM, HI/LO ownership, D-stage stall
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  count;
    logic [31:0] hi_pend;
    logic [31:0] lo_pend;
    logic        pend_wr;

    logic        is_md;
    logic        is_div;
    logic        signed_op;
    logic        accept;
    logic        last_cycle;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_md      = (md_op <= 3'd3);
    assign is_div     = md_op[1];
    assign signed_op  = ~md_op[0];
    assign accept     = (state == IDLE) && start && is_md;
    assign last_cycle = (state == RUN) && (count == 4'd1);

    // Sign/zero extension to 64 bits lets one unsigned multiplier serve mult and multu.
    always_comb begin
        ext_a = signed_op ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        ext_b = signed_op ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        prod  = ext_a * ext_b;
    end

    // Divide on magnitudes so 0x80000000 / -1 never overflows a signed divider.
    always_comb begin
        mag_a   = (signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
        mag_b   = (signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
        divisor = (src_b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (signed_op && (src_a[31] ^ src_b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem     = (signed_op && src_a[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_cycle) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        md_stall = md_use_D & (busy | (start & is_md));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            pend_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                count   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                hi_pend <= res_hi;
                lo_pend <= res_lo;
                pend_wr <= !(is_div && (src_b == 32'd0));
            end else if (start && (md_op == OP_MTHI)) begin
                hi <= src_a;
            end else if (start && (md_op == OP_MTLO)) begin
                lo <= src_a;
            end
        end else begin
            count <= count - 4'd1;
            // Divide-by-zero keeps the old HI/LO; only the latency is modelled.
            if (last_cycle && pend_wr) begin
                hi <= hi_pend;
                lo <= lo_pend;
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    int cyc;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .md_use_D (md_use_D),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        md_op = 3'd7;
    endtask

    // Counts consecutive busy samples; returns in the first cycle busy reads 0.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd7; src_a = '0; src_b = '0; md_use_D = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        chk("mult_cycles", cyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        chk("multu_cycles", cyc, 32'd5);
        chk("multu_hi", hi, 32'h0000_0004);
        chk("multu_lo", lo, 32'hFFFF_FFF1);

        issue(3'd3, 32'd17, 32'd5);
        wait_idle(cyc);
        chk("divu_cycles", cyc, 32'd10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd2);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        issue(3'd4, 32'h0000_1234, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h0000_1234);
        issue(3'd5, 32'h0000_ABCD, 32'd0);
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        chk("mtlo_hi_kept", hi, 32'h0000_1234);

        issue(3'd6, 32'hFFFF_FFFF, 32'd1);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, 32'h0000_1234);

        issue(3'd2, 32'd99, 32'd0);
        wait_idle(cyc);
        chk("div0_cycles", cyc, 32'd10);
        chk("div0_hi", hi, 32'h0000_1234);
        chk("div0_lo", lo, 32'h0000_ABCD);

        md_use_D = 1'b1;
        start = 1'b1; md_op = 3'd4; src_a = 32'h5;
        #1;
        chk("stall_mthi_issue", {31'd0, md_stall}, 32'd0);
        md_op = 3'd0; src_a = 32'd7; src_b = 32'd9;
        #1;
        chk("stall_mult_issue", {31'd0, md_stall}, 32'd1);
        step();
        start = 1'b0; md_op = 3'd7;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_busy_%0d", i), {30'd0, busy, md_stall}, 32'd3);
            step();
        end
        chk("stall_after", {30'd0, busy, md_stall}, 32'd0);
        chk("stall_mult_lo", lo, 32'd63);
        chk("stall_mult_hi", hi, 32'd0);

        md_use_D = 1'b0;
        issue(3'd0, 32'd2, 32'd3);
        chk("nouse_stall", {31'd0, md_stall}, 32'd0);
        start = 1'b1; md_op = 3'd4; src_a = 32'h0000_DEAD;
        step();
        chk("ign_mthi_hi", hi, 32'd0);
        md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        step();
        start = 1'b0; md_op = 3'd7;
        wait_idle(cyc);
        chk("ign_cycles", cyc, 32'd3);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd6);

        issue(3'd2, 32'd100, 32'd7);
        step(); step();
        chk("rst_run_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) step();
        chk("rst_run_no_commit", lo, 32'd0);

        reset = 1'b1;
        issue(3'd0, 32'd2, 32'd3);
        reset = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 7; i++) step();
        chk("rst_start_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Controller and scheduler for the pipeline's multiply/divide resource.
- Accepts one MD operation per issue from the E stage and models the fixed unit latency (mult vs div) with a down-counter FSM.
- Owns the architectural HI/LO registers and commits results only when the operation's latency has elapsed.
- Generates the busy flag and the D-stage MD stall that the hazard logic ORs into the pipeline freeze.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage MD instruction valid this cycle.
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
- src_a  input  32  forwarded rs value (E stage).
- src_b  input  32  forwarded rt value (E stage).
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  unit occupied by a mult/div.
- md_stall  output  1  stall request to freeze F/D and bubble E.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (synchronous, on a rising edge with reset=1):
  - state=IDLE, counter=0, busy=0.
  - hi=0, lo=0, pending results cleared.
  - Reset overrides start on the same edge.
  - Reset during RUN aborts the operation; HI/LO are forced to 0, not committed.
- States:
  - IDLE: waiting for an operation.
  - RUN: counting latency.
- IDLE, start=1, md_op in 0..3:
  - At the edge, latch the computed {hi_pend, lo_pend}.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), then go to RUN.
- IDLE, start=1, md_op 4/5: hi<=src_a (mthi) or lo<=src_a (mtlo) at that edge; remain in IDLE; busy stays 0.
- IDLE, start=1, md_op 6/7: no effect.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter equals 1: hi<=hi_pend, lo<=lo_pend, state goes to IDLE, busy falls.
  - busy is therefore high for exactly N cycles after the start edge, and the new HI/LO are visible in the cycle busy first reads 0.
  - start in RUN (any md_op) is ignored; HI/LO and counter are unaffected. The hazard stall prevents this, and the bench checks the ignore behaviour.
- busy = (state==RUN), registered.
- md_stall = md_use_D & (busy | (start & md_op<=3)), combinational.
  - Covers the issue cycle before busy rises.
  - mthi/mtlo in E never stall D.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned. HI=upper 32, LO=lower 32.
  - div: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned.
  - Divisor 0 (div/divu): busy for DIV_CYCLES as normal; HI/LO unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Operands are sampled only at the start edge; later changes of src_a/src_b have no effect.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. the cycle right after the commit edge.

Test Plan:
- mult, src_a=0xFFFFFFFD (-3), src_b=5 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- divu 17/5 -> busy=1 for 10 cycles; then lo=3, hi=2. div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x1234 then mtlo 0xABCD, then div x/0 -> busy for 10 cycles; hi=0x1234, lo=0xABCD afterwards.
- md_use_D=1 with start=1, md_op=0 -> md_stall=1 in the issue cycle and all 5 busy cycles, 0 after. With md_op=4 -> md_stall=0.
- During RUN of a mult 2*3, pulse start with mthi src_a=0xDEAD and with div -> ignored; commit gives hi=0, lo=6 at the original cycle count.
- reset asserted in RUN cycle 3 of a div -> next cycle busy=0, hi=lo=0, no later commit. Reset coincident with start -> op not accepted.
